// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field positions and the
// fetch sequencer state enum. FETCH_WATCHDOG_EN adds the terminal HALT state.
package cpu_pkg;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_SLTI = 3'd1;
    localparam logic [2:0] OP_J    = 3'd2;
    localparam logic [2:0] OP_JAL  = 3'd3;
    localparam logic [2:0] OP_LW   = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_ADDI = 3'd7;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 13;
    localparam int JTGT_HI = 12;
    localparam int BOFF_HI = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_RESOLVE
`ifdef FETCH_WATCHDOG_EN
        , ST_HALT
`endif
    } seq_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch, or sequential PC+1.
// All arithmetic wraps modulo 2^PC_W.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    input  logic            jump,
    input  logic            branch,
    input  logic            alu_zero,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_off;
    logic            unused_instr;

    // Sign-extend the 7-bit branch offset to 16 bits, then keep the PC-width slice.
    function automatic logic [PC_W-1:0] sext_off(input logic [BOFF_HI:0] off);
        logic signed [15:0] wide;
        wide = {{(15 - BOFF_HI){off[BOFF_HI]}}, off};
        return wide[PC_W-1:0];
    endfunction

    assign pc_inc       = pc + PC_W'(1);
    assign br_off       = sext_off(instr[BOFF_HI:0]);
    assign unused_instr = ^instr;

    always_comb begin
        next_pc = pc_inc;
        if (jump) begin
            next_pc = instr[PC_W-1:0];
        end else if (branch && alu_zero) begin
            next_pc = pc_inc + br_off;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> FETCH -> ISSUE -> RESOLVE loop feeding the decoder.
// Optional fetch watchdog (sticky fetch_err, terminal HALT) enabled by FETCH_WATCHDOG_EN.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    output logic [2:0]      opcode,
    output logic            instr_valid,
    input  logic            jump,
    input  logic            branch,
    input  logic            alu_zero,
    input  logic            stall,
    output logic [PC_W-1:0] link_pc,
    output logic            fetch_err
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] link_q, link_d;
    logic [PC_W-1:0] npc;

`ifdef FETCH_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    next_pc_calc #(.PC_W(PC_W)) u_next_pc (
        .pc       (pc_q),
        .instr    (instr_q),
        .jump     (jump),
        .branch   (branch),
        .alu_zero (alu_zero),
        .next_pc  (npc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        instr_d = instr_q;
        link_d  = link_q;
`ifdef FETCH_WATCHDOG_EN
        wd_d    = '0;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    link_d  = pc_q + PC_W'(1);
                    req_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
`ifdef FETCH_WATCHDOG_EN
                else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_HALT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            ST_ISSUE: begin
                state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                // Decoder outputs are valid here; a stall freezes everything.
                if (!stall) begin
                    pc_d    = npc;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
`ifdef FETCH_WATCHDOG_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            instr_q <= '0;
            link_q  <= '0;
`ifdef FETCH_WATCHDOG_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            link_q  <= link_d;
`ifdef FETCH_WATCHDOG_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPC_HI:OPC_LO];
    assign instr_valid = (state_q == ST_ISSUE);
    assign link_pc     = link_q;
`ifdef FETCH_WATCHDOG_EN
    assign fetch_err   = err_q;
`else
    assign fetch_err   = 1'b0;
`endif

endmodule
